// File: rtl/alu_result_fifo.sv
// alu_result_fifo: output stage of the structural ALU.
// Picks one flagged unit result per cycle (arith > logic > cmp > shift),
// tags it with its source unit, and buffers it in a first-word-fall-through
// FIFO that drains over a valid/ready handshake. Keeps an occupancy count
// and sticky overflow / multi-flag error flags.
//
// Handshake: an entry transfers to the consumer on a rising clk edge where
// res_valid and res_ready are both high. res_valid never depends on
// res_ready, and once raised it stays high (with res_data/res_tag stable)
// until that transfer happens. res_ready is ignored while res_valid is low.
module alu_result_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        arith_out,
    input  logic [DATA_WIDTH-1:0]        logic_out,
    input  logic [DATA_WIDTH-1:0]        cmp_out,
    input  logic [DATA_WIDTH-1:0]        shift_out,
    input  logic                         arith_flag,
    input  logic                         logic_flag,
    input  logic                         cmp_flag,
    input  logic                         shift_flag,
    input  logic                         res_ready,
    input  logic                         clr_err,
    output logic [DATA_WIDTH-1:0]        res_data,
    output logic [1:0]                   res_tag,
    output logic                         res_valid,
    output logic                         fifo_full,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic                         ovf_err,
    output logic                         multi_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    localparam logic [1:0] TAG_ARITH = 2'b00;
    localparam logic [1:0] TAG_LOGIC = 2'b01;
    localparam logic [1:0] TAG_CMP   = 2'b10;
    localparam logic [1:0] TAG_SHIFT = 2'b11;

    // Storage (no reset: contents are don't-care until written)
    logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_d [DEPTH];
    logic [1:0]            mem_tag_q  [DEPTH];
    logic [1:0]            mem_tag_d  [DEPTH];

    // Control state
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          full_q,   full_d;
    logic          ovf_q,    ovf_d;
    logic          multi_q,  multi_d;

    // Per-cycle decode
    logic                  push_req;
    logic                  push_acc;
    logic                  push_drop;
    logic                  pop;
    logic                  multi_evt;
    logic [DATA_WIDTH-1:0] push_data;
    logic [1:0]            push_tag;
    logic                  not_empty;

    // Head is visible whenever anything is stored; derived only from state.
    assign not_empty = (count_q != CNT_ZERO);

    // Select the winning unit and decide push/pop/drop for this cycle.
    always_comb begin
        push_req  = arith_flag | logic_flag | cmp_flag | shift_flag;
        push_data = '0;
        push_tag  = TAG_ARITH;
        if (arith_flag) begin
            push_data = arith_out;
            push_tag  = TAG_ARITH;
        end else if (logic_flag) begin
            push_data = logic_out;
            push_tag  = TAG_LOGIC;
        end else if (cmp_flag) begin
            push_data = cmp_out;
            push_tag  = TAG_CMP;
        end else if (shift_flag) begin
            push_data = shift_out;
            push_tag  = TAG_SHIFT;
        end
        // More than one flag: any pair of flags high at once.
        multi_evt = (arith_flag & (logic_flag | cmp_flag | shift_flag))
                  | (logic_flag & (cmp_flag | shift_flag))
                  | (cmp_flag & shift_flag);
        pop       = not_empty & res_ready;
        // When full, a same-cycle pop frees the slot the push needs.
        push_acc  = push_req & (~full_q | pop);
        push_drop = push_req & full_q & ~pop;
    end

    // Next-state for pointers, count, full flag and sticky errors.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        unique case ({push_acc, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_DEPTH);
        // A new error event outranks a same-cycle clear.
        ovf_d   = push_drop ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
        multi_d = multi_evt ? 1'b1 : (clr_err ? 1'b0 : multi_q);
    end

    // Next-state for storage: write the accepted entry at wr_ptr.
    always_comb begin
        mem_data_d = mem_data_q;
        mem_tag_d  = mem_tag_q;
        if (push_acc) begin
            mem_data_d[wr_ptr_q] = push_data;
            mem_tag_d[wr_ptr_q]  = push_tag;
        end
    end

    // Control registers; asynchronous reset discards all buffered entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            multi_q  <= multi_d;
        end
    end

    // Storage registers; contents only become meaningful once counted.
    always_ff @(posedge clk) begin
        mem_data_q <= mem_data_d;
        mem_tag_q  <= mem_tag_d;
    end

    // Head output falls through from storage, forced to zero while empty.
    always_comb begin
        res_valid = not_empty;
        res_data  = '0;
        res_tag   = 2'b00;
        if (not_empty) begin
            res_data = mem_data_q[rd_ptr_q];
            res_tag  = mem_tag_q[rd_ptr_q];
        end
    end

    assign fifo_full  = full_q;
    assign fifo_count = count_q;
    assign ovf_err    = ovf_q;
    assign multi_err  = multi_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed scenarios plus random traffic, all
// checked against a queue-based model of the result FIFO.
module tb_alu_result_fifo;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned OW    = 1 + DW + 2 + CW + 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] arith_out, logic_out, cmp_out, shift_out;
    logic          arith_flag, logic_flag, cmp_flag, shift_flag;
    logic          res_ready, clr_err;
    logic [DW-1:0] res_data;
    logic [1:0]    res_tag;
    logic          res_valid, fifo_full, ovf_err, multi_err;
    logic [CW-1:0] fifo_count;

    alu_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .arith_out(arith_out), .logic_out(logic_out),
        .cmp_out(cmp_out), .shift_out(shift_out),
        .arith_flag(arith_flag), .logic_flag(logic_flag),
        .cmp_flag(cmp_flag), .shift_flag(shift_flag),
        .res_ready(res_ready), .clr_err(clr_err),
        .res_data(res_data), .res_tag(res_tag), .res_valid(res_valid),
        .fifo_full(fifo_full), .fifo_count(fifo_count),
        .ovf_err(ovf_err), .multi_err(multi_err)
    );

    // reference model: queue of {tag, data}, plus sticky error bits
    logic [DW+1:0] exp_q[$];
    logic          m_ovf;
    logic          m_multi;

    int vectors    = 0;
    int miscompares = 0;

    function automatic logic [OW-1:0] obs_vec();
        return {res_valid, res_data, res_tag, fifo_count, fifo_full, ovf_err, multi_err};
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        logic          v;
        logic [DW+1:0] head;
        int            n;
        n    = exp_q.size();
        v    = (n != 0);
        head = v ? exp_q[0] : '0;
        return {v, head[DW-1:0], head[DW+1:DW], CW'(n), (n == DEPTH), m_ovf, m_multi};
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_multi = 1'b0;
    endfunction

    // Apply the FIFO rules to the inputs sampled at this edge.
    function automatic void model_edge();
        int            nflags;
        logic          pop, full, req;
        logic [DW+1:0] ent;
        nflags = int'(arith_flag) + int'(logic_flag) + int'(cmp_flag) + int'(shift_flag);
        req    = (nflags > 0);
        if (arith_flag)      ent = {2'd0, arith_out};
        else if (logic_flag) ent = {2'd1, logic_out};
        else if (cmp_flag)   ent = {2'd2, cmp_out};
        else                 ent = {2'd3, shift_out};
        pop  = (exp_q.size() > 0) && res_ready;
        full = (exp_q.size() == DEPTH);
        if (pop) void'(exp_q.pop_front());
        if (req && (!full || pop)) exp_q.push_back(ent);
        m_ovf   = (req && full && !pop) ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
        m_multi = (nflags > 1)          ? 1'b1 : (clr_err ? 1'b0 : m_multi);
    endfunction

    // driver tasks
    task automatic drive_idle();
        arith_flag = 0; logic_flag = 0; cmp_flag = 0; shift_flag = 0;
        clr_err    = 0;
        arith_out  = DW'($urandom); logic_out = DW'($urandom);
        cmp_out    = DW'($urandom); shift_out = DW'($urandom);
    endtask

    task automatic drive_push(input int unit, input logic [DW-1:0] d);
        drive_idle();
        case (unit)
            0: begin arith_flag = 1; arith_out = d; end
            1: begin logic_flag = 1; logic_out = d; end
            2: begin cmp_flag   = 1; cmp_out   = d; end
            default: begin shift_flag = 1; shift_out = d; end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        res_ready = 0;
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        if (obs_vec() !== exp_vec() || obs_vec() !== '0) begin
            miscompares++;
            $display("FAIL reset: got %h exp %h", obs_vec(), exp_vec());
        end
        vectors++;
        @(negedge clk);
        rst = 1;
        #1;
    endtask

    task automatic test_single_shift();
        drive_push(3, 16'h1234);
        res_ready = 0;
        step();
        drive_idle();
        if (obs_vec() !== exp_vec() || res_valid !== 1'b1 || res_data !== 16'h1234 ||
            res_tag !== 2'b11 || fifo_count !== CW'(1)) begin
            miscompares++;
            $display("FAIL single_shift: got %h exp %h", obs_vec(), exp_vec());
        end
        vectors++;
        res_ready = 1;
        step();
        res_ready = 0;
        if (obs_vec() !== exp_vec() || res_valid !== 1'b0 || fifo_count !== CW'(0)) begin
            miscompares++;
            $display("FAIL single_pop: got %h exp %h", obs_vec(), exp_vec());
        end
        vectors++;
    endtask

    task automatic test_ordering();
        res_ready = 0;
        for (int i = 0; i < 4; i++) begin
            drive_push(i, DW'(i + 1));
            step();
        end
        drive_idle();
        if (obs_vec() !== exp_vec() || fifo_full !== 1'b1) begin
            miscompares++;
            $display("FAIL order_full: got %h exp %h", obs_vec(), exp_vec());
        end
        vectors++;
        res_ready = 1;
        for (int i = 0; i < 4; i++) begin
            if (res_data !== DW'(i + 1) || res_tag !== 2'(i) || res_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL order_head%0d: got %h/%0d exp %h/%0d", i, res_data, res_tag, i + 1, i);
            end
            vectors++;
            step();
        end
        res_ready = 0;
        if (obs_vec() !== exp_vec() || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL order_drained: got %h exp %h", obs_vec(), exp_vec());
        end
        vectors++;
    endtask

    task automatic test_overflow();
        res_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_push($urandom_range(0, 3), DW'($urandom_range(0, 16'hBEEE)));
            step();
        end
        drive_push(3, 16'hBEEF);
        step();
        drive_idle();
        if (obs_vec() !== exp_vec() || ovf_err !== 1'b1 || fifo_count !== CW'(DEPTH)) begin
            miscompares++;
            $display("FAIL overflow: got %h exp %h", obs_vec(), exp_vec());
        end
        vectors++;
        clr_err = 1;
        step();
        clr_err = 0;
        if (obs_vec() !== exp_vec() || ovf_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: got %h exp %h", obs_vec(), exp_vec());
        end
        vectors++;
        // clear and a new drop in the same cycle: the set wins
        drive_push(1, 16'hBEEF);
        clr_err = 1;
        step();
        drive_idle();
        if (obs_vec() !== exp_vec() || ovf_err !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set_wins: got %h exp %h", obs_vec(), exp_vec());
        end
        vectors++;
        clr_err   = 1;
        res_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (res_data === 16'hBEEF || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL ovf_drain%0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
            vectors++;
            step();
            clr_err = 0;
        end
        res_ready = 0;
    endtask

    task automatic test_full_pop_push();
        logic [DW-1:0] last;
        res_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_push($urandom_range(0, 3), DW'($urandom_range(0, 16'h7FFF)));
            step();
        end
        drive_push(0, 16'hAAAA);
        res_ready = 1;
        step();
        drive_idle();
        if (obs_vec() !== exp_vec() || fifo_count !== CW'(DEPTH) || ovf_err !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop_push: got %h exp %h", obs_vec(), exp_vec());
        end
        vectors++;
        last = '0;
        for (int i = 0; i < DEPTH; i++) begin
            last = res_data;
            step();
        end
        res_ready = 0;
        if (last !== 16'hAAAA || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL full_last: got %h exp %h", last, 16'hAAAA);
        end
        vectors++;
    endtask

    task automatic test_multi_flag();
        drive_idle();
        arith_out = 16'h0011; arith_flag = 1;
        shift_out = 16'h0022; shift_flag = 1;
        res_ready = 0;
        step();
        drive_idle();
        if (obs_vec() !== exp_vec() || res_data !== 16'h0011 || res_tag !== 2'b00 ||
            multi_err !== 1'b1 || fifo_count !== CW'(1)) begin
            miscompares++;
            $display("FAIL multi_flag: got %h exp %h", obs_vec(), exp_vec());
        end
        vectors++;
        clr_err   = 1;
        res_ready = 1;
        step();
        drive_idle();
        res_ready = 0;
        if (obs_vec() !== exp_vec() || multi_err !== 1'b0) begin
            miscompares++;
            $display("FAIL multi_clear: got %h exp %h", obs_vec(), exp_vec());
        end
        vectors++;
    endtask

    task automatic test_wrap_and_reset();
        logic [DW-1:0] d;
        for (int i = 0; i < 10; i++) begin
            d = DW'($urandom);
            drive_push($urandom_range(0, 3), d);
            res_ready = 0;
            step();
            drive_idle();
            if (obs_vec() !== exp_vec() || res_data !== d) begin
                miscompares++;
                $display("FAIL wrap_push%0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
            vectors++;
            res_ready = 1;
            step();
            res_ready = 0;
        end
        for (int i = 0; i < 3; i++) begin
            drive_push($urandom_range(0, 3), DW'($urandom));
            step();
        end
        drive_idle();
        rst = 0;
        model_reset();
        #1;
        if (obs_vec() !== exp_vec() || obs_vec() !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %h exp %h", obs_vec(), exp_vec());
        end
        vectors++;
        @(negedge clk);
        rst = 1;
        d = DW'($urandom);
        drive_push(2, d);
        step();
        drive_idle();
        if (obs_vec() !== exp_vec() || res_data !== d || res_tag !== 2'b10 ||
            fifo_count !== CW'(1)) begin
            miscompares++;
            $display("FAIL post_reset_push: got %h exp %h", obs_vec(), exp_vec());
        end
        vectors++;
        res_ready = 1;
        step();
        res_ready = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_idle();
            arith_flag = ($urandom_range(0, 99) < 25);
            logic_flag = ($urandom_range(0, 99) < 25);
            cmp_flag   = ($urandom_range(0, 99) < 25);
            shift_flag = ($urandom_range(0, 99) < 25);
            res_ready  = ($urandom_range(0, 99) < 45);
            clr_err    = ($urandom_range(0, 99) < 10);
            step();
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random%0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
            vectors++;
        end
        drive_idle();
        res_ready = 0;
    endtask

    initial begin
        res_ready = 0;
        drive_idle();
        model_reset();
        test_reset();
        test_single_shift();
        test_ordering();
        test_overflow();
        test_full_pop_push();
        test_multi_flag();
        test_wrap_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Output stage of the structural ALU, directly downstream of the arithmetic, logic, compare and shift units. Each cycle it takes the one unit whose registered flag is high, tags that unit's registered result, and pushes it into a small first-word-fall-through FIFO. The FIFO drains to the consumer over a valid/ready handshake. It also counts buffered results and raises sticky error flags for overflow and for multiple flags in one cycle.

## Interface
- DATA_WIDTH, 16, width of every unit result and of res_data
- DEPTH, 4, FIFO entries; power of two, minimum 2
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- arith_out / logic_out / cmp_out / shift_out  in  DATA_WIDTH each  registered unit results
- arith_flag / logic_flag / cmp_flag / shift_flag  in  1 each  result-valid flag of each unit
- res_ready  in  1  consumer accepts the head entry this cycle
- clr_err  in  1  synchronous clear of the sticky error flags
- res_data  out  DATA_WIDTH  head entry data
- res_tag  out  2  head entry source unit: 00 arith, 01 logic, 10 cmp, 11 shift
- res_valid  out  1  FIFO is not empty
- fifo_full  out  1  count equals DEPTH
- fifo_count  out  $clog2(DEPTH)+1  number of stored entries
- ovf_err  out  1  sticky: a push was dropped because the FIFO was full
- multi_err  out  1  sticky: more than one unit flag was high in the same cycle

## Operation
- Reset values: all outputs 0, rd_ptr/wr_ptr 0, storage contents don't-care. res_data and res_tag are 0 while empty.
- Push request: push_req = OR of the four flags.
- Selection priority when more than one flag is high: arith > logic > cmp > shift. Only the winner is pushed. multi_err sets in that cycle.
- Pop: pop = res_valid & res_ready. res_ready while empty is ignored.
- Push acceptance: accepted when !fifo_full, or when fifo_full and pop happen in the same cycle (simultaneous pop+push when full).
- Dropped push: when fifo_full, push_req and no pop, the entry is discarded, ovf_err sets, and count and pointers are unchanged.
- Count update: push only +1; pop only -1; push and pop together leaves count unchanged.
- Pointers: $clog2(DEPTH) bits; they wrap naturally from DEPTH-1 to 0.
- Head output: res_data/res_tag come combinationally from the entry at rd_ptr (registered storage), so the head is first-word-fall-through.
- No bypass: a push into an empty FIFO becomes visible on the next cycle.
- Sticky errors: set by their events and held until clr_err. If clr_err and a new error event occur in the same cycle, the set wins.
- Reset mid-operation: all buffered entries are discarded immediately (asynchronous); nothing is replayed after reset.

## Timing
- Latency: flag high at edge N is captured at edge N+1. res_valid, res_data and res_tag update right after edge N+1, so latency is 1 cycle from flag to res_valid.
- Pop: a pop sampled at edge M presents the next entry (or res_valid=0) right after edge M.
- fifo_full, fifo_count, ovf_err, multi_err: registered; they reflect the edge that caused them.
- Throughput: one push and one pop per cycle sustained. With res_ready held high, the FIFO never fills.
- Combinational paths: none from res_ready to res_valid/res_data. The only combinational read path is storage → head output.

## Test plan
- Reset then single shift: rst low→high, shift_out=16'h1234 with shift_flag for 1 cycle, res_ready=0 → next cycle res_valid=1, res_data=16'h1234, res_tag=11, fifo_count=1. Pulsing res_ready → res_valid=0, count=0.
- Ordering: push arith 16'h0001, logic 16'h0002, cmp 16'h0003, shift 16'h0004 on consecutive cycles, then drain with res_ready=1 → data 1,2,3,4 with tags 00,01,10,11 in order; fifo_full=1 after the 4th push.
- Overflow: with the FIFO full and res_ready=0, push shift 16'hBEEF → ovf_err=1, count stays 4, 16'hBEEF never appears. Then clr_err → ovf_err=0.
- Full with simultaneous pop+push: full FIFO, res_ready=1 and arith_flag with 16'hAAAA in the same cycle → count stays 4, ovf_err=0, 16'hAAAA is the last entry drained.
- Multi-flag: arith_out=16'h0011 and shift_out=16'h0022 with both flags high → one entry pushed, 16'h0011 tag 00; multi_err=1; count=1.
- Wrap and reset: 10 push/pop pairs to wrap the pointers with data checked each time, then assert rst with 3 entries buffered → res_valid=0, count=0, errors=0 immediately. The first push after reset is read back correctly.
